// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Latency: start accepted in IDLE, 32 CALC cycles, fin pulses in DONE
//   (the 33rd cycle after start); fast path goes straight to DONE (cycle 1).
// Backpressure: none; busy=1 while CALC/DONE, requests during busy are dropped.
// Ports: clk, rst (sync, active-high); is_m/is_d start requests, funct3 op,
//   src1/src2 operands, flush abort; busy, fin pulse, result (held while fin=0).
// Optional feature macro: MULDIV_FASTPATH_EN (zero/overflow operands skip CALC).
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_m,
  input  logic        is_d,
  input  logic [2:0]  funct3,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        busy,
  output logic        fin,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]  cnt;
  logic [31:0] hi, lo, a, dvd_raw, held;
  logic        op_mul, neg1, neg2, div0, ovf, mzero;
  logic [1:0]  op_f;

  // Input decode: multiply wins when both requests are raised.
  logic        start, in_mul, in_s1, in_s2, in_n1, in_n2;
  logic        in_div0, in_ovf, in_mzero, skip;
  logic [1:0]  in_f;
  logic [31:0] m1, m2;

  always_comb begin
    start    = (is_m | is_d) & ~flush;
    in_mul   = is_m;
    in_f     = funct3[1:0];
    in_s1    = in_mul ? (in_f == 2'b01 || in_f == 2'b10) : ~in_f[0];
    in_s2    = in_mul ? (in_f == 2'b01) : ~in_f[0];
    in_n1    = in_s1 & src1[31];
    in_n2    = in_s2 & src2[31];
    m1       = in_n1 ? (32'd0 - src1) : src1;
    m2       = in_n2 ? (32'd0 - src2) : src2;
    in_div0  = ~in_mul & (src2 == 32'd0);
    in_ovf   = ~in_mul & ~in_f[0] & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
    in_mzero = in_mul & ((src1 == 32'd0) | (src2 == 32'd0));
`ifdef MULDIV_FASTPATH_EN
    skip     = in_div0 | in_ovf | in_mzero;
`else
    skip     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = skip ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One radix-2 step. Multiply: shift-add with {hi,lo} as the 64-bit
  // product, lo initially holding the multiplier. Divide: restoring, hi is
  // the partial remainder and lo shifts dividend bits out / quotient bits in.
  logic [32:0] mul_sum, div_sh, div_diff;
  logic [31:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a} : 33'd0);
    div_sh   = {hi, lo[31]};
    div_diff = div_sh - {1'b0, a};
    if (op_mul) begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], lo[31:1]};
    end else if (!div_diff[32]) begin
      step_hi = div_diff[31:0];
      step_lo = {lo[30:0], 1'b1};
    end else begin
      step_hi = div_sh[31:0];
      step_lo = {lo[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; hi <= '0; lo <= '0; a <= '0; dvd_raw <= '0; held <= '0;
      op_mul <= 1'b0; op_f <= '0; neg1 <= 1'b0; neg2 <= 1'b0;
      div0 <= 1'b0; ovf <= 1'b0; mzero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt <= '0; hi <= '0; lo <= m1; a <= m2; dvd_raw <= src1;
          op_mul <= in_mul; op_f <= in_f; neg1 <= in_n1; neg2 <= in_n2;
          div0 <= in_div0; ovf <= in_ovf; mzero <= in_mzero;
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          hi  <= step_hi;
          lo  <= step_lo;
        end
        DONE:    held <= res_calc;
        default: ;
      endcase
    end
  end

  // Sign correction and special cases applied to the finished magnitudes.
  logic [63:0] prod, prod_s;
  logic [31:0] quo, rem, mul_res, div_res, res_calc;

  always_comb begin
    prod    = {hi, lo};
    prod_s  = (neg1 ^ neg2) ? (64'd0 - prod) : prod;
    mul_res = mzero ? 32'd0 : ((op_f == 2'b00) ? prod_s[31:0] : prod_s[63:32]);
    quo     = (neg1 ^ neg2) ? (32'd0 - lo) : lo;
    rem     = neg1 ? (32'd0 - hi) : hi;
    if (div0) begin
      quo = 32'hFFFF_FFFF;
      rem = dvd_raw;
    end else if (ovf) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end
    div_res  = op_f[1] ? rem : quo;
    res_calc = op_mul ? mul_res : div_res;
  end

  assign busy   = (state != IDLE);
  assign fin    = (state == DONE);
  assign result = fin ? res_calc : held;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit.
// Latency: checks fin cycle (33, or 1 for fast-path operands when built with
//   MULDIV_FASTPATH_EN) and result; hand sequences cover flush/reset/ignore.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, is_m, is_d, flush;
  logic [2:0]  funct3;
  logic [31:0] src1, src2;
  logic        busy, fin;
  logic [31:0] result;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .is_m(is_m), .is_d(is_d), .funct3(funct3),
    .src1(src1), .src2(src2), .flush(flush),
    .busy(busy), .fin(fin), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit        m, d;
    bit [2:0]  f;
    bit [31:0] a, b, exp;
    bit        fast;
    string     name;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input bit m, input bit d, input bit [2:0] f, input bit [31:0] a,
                      input bit [31:0] b, input bit [31:0] e, input bit fast, input string nm);
    vec_t v;
    v.m = m; v.d = d; v.f = f; v.a = a; v.b = b; v.exp = e; v.fast = fast; v.name = nm;
    vecs.push_back(v);
  endtask

  // Scoreboard: every fin pops one expectation and checks value and cycle.
  always @(negedge clk) begin
    if (fin === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fin: got fin=1 result=%h want no fin", result);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check({e.name, "_res"}, result, e.exp);
        check({e.name, "_cyc"}, cyc, e.due);
      end
    end
  end

  function automatic int lat_of(input bit fast);
`ifdef MULDIV_FASTPATH_EN
    return fast ? 1 : 33;
`else
    return fast ? 33 : 33;
`endif
  endfunction

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no fin want fin within 60 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic drive_start(input bit m, input bit d, input bit [2:0] f,
                             input bit [31:0] a, input bit [31:0] b);
    @(negedge clk);
    is_m = m; is_d = d; funct3 = f; src1 = a; src2 = b;
  endtask

  task automatic scramble();
    is_m = 1'b0; is_d = 1'b0;
    src1 = $urandom; src2 = $urandom; funct3 = 3'($urandom);
  endtask

  task automatic run_op(input vec_t v);
    sb_t e;
    drive_start(v.m, v.d, v.f, v.a, v.b);
    e.exp = v.exp; e.due = cyc + lat_of(v.fast); e.name = v.name;
    sb.push_back(e);
    @(negedge clk);
    scramble();
    wait_drain(v.name);
  endtask

  initial begin
    sb_t e;
    int  nb;
    vec_t v;

    addv(1, 0, 3'b000, 32'd7,          32'd6,          32'd42,         0, "mul_7x6");
    addv(1, 0, 3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   0, "mulh_m1m1");
    addv(1, 0, 3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   0, "mulhu_max");
    addv(1, 0, 3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   0, "mul_max_lo");
    addv(1, 0, 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   0, "mulhsu_m1");
    addv(1, 0, 3'b001, 32'h80000000,   32'h80000000,   32'h40000000,   0, "mulh_min");
    addv(1, 0, 3'b000, 32'd0,          32'd12345,      32'd0,          1, "mul_zero");
    addv(0, 1, 3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   0, "div_m7_2");
    addv(0, 1, 3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   0, "rem_m7_2");
    addv(0, 1, 3'b101, 32'd5,          32'd0,          32'hFFFFFFFF,   1, "divu_by0");
    addv(0, 1, 3'b111, 32'd5,          32'd0,          32'd5,          1, "remu_by0");
    addv(0, 1, 3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1, "div_ovf");
    addv(0, 1, 3'b110, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1, "rem_ovf");
    addv(0, 1, 3'b100, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1, "div_neg_by0");
    addv(0, 1, 3'b110, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1, "rem_neg_by0");
    addv(0, 1, 3'b101, 32'd100,        32'd7,          32'd14,         0, "divu_100_7");
    addv(0, 1, 3'b111, 32'd100,        32'd7,          32'd2,          0, "remu_100_7");
    addv(0, 1, 3'b110, 32'd7,          32'hFFFFFFFE,   32'd1,          0, "rem_7_m2");
    addv(1, 1, 3'b100, 32'd3,          32'd5,          32'd15,         0, "both_is_mul");
    addv(1, 0, 3'b010, 32'd2,          32'hFFFFFFFF,   32'd1,          0, "mulhsu_2");

    rst = 1'b1; is_m = 1'b0; is_d = 1'b0; flush = 1'b0;
    funct3 = 3'b000; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fin", {31'd0, fin}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // result holds after fin drops
    repeat (3) @(negedge clk);
    check("result_hold", result, vecs[vecs.size()-1].exp);

    // busy lasts exactly 33 cycles for a plain multiply
    drive_start(1, 0, 3'b000, 32'd7, 32'd6);
    e.exp = 32'd42; e.due = cyc + 33; e.name = "busy_mul";
    sb.push_back(e);
    @(negedge clk);
    scramble();
    nb = 0;
    repeat (40) begin
      if (busy) nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, 32'd33);
    wait_drain("busy_mul");

    // start requests during CALC are ignored
    drive_start(1, 0, 3'b000, 32'd5, 32'd5);
    e.exp = 32'd25; e.due = cyc + 33; e.name = "ignore_req";
    sb.push_back(e);
    repeat (20) begin
      @(negedge clk);
      is_m = 1'b1; is_d = 1'($urandom); funct3 = 3'($urandom);
      src1 = $urandom; src2 = $urandom;
    end
    @(negedge clk);
    scramble();
    wait_drain("ignore_req");
    @(negedge clk);
    check("ignore_idle_busy", {31'd0, busy}, 32'd0);

    // flush at CALC cycle 10, then an immediate MUL 3x3
    drive_start(0, 1, 3'b101, 32'd100, 32'd7);
    @(negedge clk);
    scramble();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_fin", {31'd0, fin}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    v.m = 1; v.d = 0; v.f = 3'b000; v.a = 32'd3; v.b = 32'd3; v.exp = 32'd9;
    v.fast = 0; v.name = "mul_after_flush";
    run_op(v);

    // flush together with a start cancels it
    drive_start(1, 0, 3'b000, 32'd2, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    scramble();
    repeat (2) @(negedge clk);

    // flush in DONE must not suppress fin
    drive_start(1, 0, 3'b011, 32'h00010000, 32'h00010000);
    e.exp = 32'd1; e.due = cyc + 33; e.name = "flush_in_done";
    sb.push_back(e);
    @(negedge clk);
    scramble();
    repeat (31) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    wait_drain("flush_in_done");

    // reset at CALC cycle 5 clears everything
    drive_start(0, 1, 3'b100, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    scramble();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_fin", {31'd0, fin}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v.m = 1; v.d = 0; v.f = 3'b000; v.a = 32'd11; v.b = 32'd13; v.exp = 32'd143;
    v.fast = 0; v.name = "mul_after_rst";
    run_op(v);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port is_m, input, 1 bit: multiply start request from decode.
REQ-004 The block SHALL have port is_d, input, 1 bit: divide start request from decode.
REQ-005 The block SHALL have port funct3, input, 3 bits: operation select (see REQ-013).
REQ-006 The block SHALL have port src1, input, 32 bits: multiplicand or dividend.
REQ-007 The block SHALL have port src2, input, 32 bits: multiplier or divisor.
REQ-008 The block SHALL have port flush, input, 1 bit: pipeline flush; aborts the operation in flight.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port fin, output, 1 bit: result valid, one-cycle pulse consumed by the hazard unit.
REQ-011 The block SHALL have port result, output, 32 bits: operation result, valid while fin=1.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC and DONE; busy SHALL be 1 in CALC and DONE.
REQ-013 The funct3 encoding SHALL be: with is_m, 000 MUL (low 32), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high); with is_d, 100 DIV, 101 DIVU, 110 REM, 111 REMU, following RISC-V M semantics.
REQ-014 A start SHALL be accepted only in IDLE; is_m and is_d seen in CALC or DONE SHALL be ignored.
REQ-015 If is_m and is_d are both 1, the block SHALL treat the request as a multiply.
REQ-016 On start, the block SHALL capture src1, src2 and funct3; later changes to these inputs SHALL NOT affect the result.
REQ-017 Multiply and divide SHALL be iterative radix-2 on operand magnitudes, one bit per cycle, with exactly 32 cycles in CALC, followed by sign correction.
REQ-018 Latency: fin SHALL be 1 in the 33rd cycle after the start cycle (DONE state), for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-019 A new start SHALL be accepted in the cycle after DONE.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-022 flush=1 in CALC SHALL force IDLE at the next edge with no fin pulse.
REQ-023 flush=1 coincident with a start in IDLE SHALL cancel the start.
REQ-024 flush=1 in DONE SHALL NOT suppress fin.
REQ-025 result SHALL hold its last value while fin=0.

Reset
REQ-026 rst=1 SHALL force IDLE at the next edge, including in the middle of an operation, with busy=0, fin=0 and result=0.
REQ-027 Reset SHALL take priority over start and flush.

Configuration
REQ-028 Macro MULDIV_FASTPATH_EN defined: divide by zero, signed overflow, and multiply with either operand zero SHALL skip CALC; the FSM goes IDLE to DONE and fin=1 in the 1st cycle after the start cycle.
REQ-029 Macro MULDIV_FASTPATH_EN undefined: all operations SHALL take the REQ-018 latency and give identical results.

Verification
REQ-030 MUL with src1=7, src2=6 -> busy=1 for 33 cycles; fin pulse in cycle 33 with result=42.
REQ-031 MULH with 0xFFFFFFFF × 0xFFFFFFFF -> result=0x00000000; MULHU with the same operands -> result=0xFFFFFFFE.
REQ-032 DIV with -7 / 2 -> result=0xFFFFFFFD; REM with the same operands -> result=0xFFFFFFFF.
REQ-033 DIVU 5/0 -> result=0xFFFFFFFF; REMU 5/0 -> result=5; fin at cycle 1 with MULDIV_FASTPATH_EN defined, cycle 33 without.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000; REM with the same operands -> result=0.
REQ-035 flush at CALC cycle 10 -> no fin, busy=0 the next cycle; an immediate MUL 3×3 -> result=9 after 33 cycles. Separately, rst at CALC cycle 5 -> all outputs 0 the next cycle.
